sap_regbank: RTL

- Parametrised successor to the SAP-1 single load-enabled B register.
- Holds DEPTH general-purpose registers of WIDTH bits, with one write/modify port and two combinational read ports.
- Supports per-cycle operations: hold, load, increment, decrement, shift left, shift right, clear and rotate right.
- Keeps zero and carry flags for the SAP-2 style ALU/controller.

---
 rtl/sap_regbank.sv | 102 ++++++++++
 1 files changed

// File: rtl/sap_regbank.sv
// Parametrised register bank with one modify port, two combinational read ports,
// and zero/carry flags feeding a SAP-2 style controller.
module sap_regbank #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic [2:0]       op,
   input  logic [AW-1:0]    wsel,
   input  logic [WIDTH-1:0] in,
   input  logic [AW-1:0]    asel,
   input  logic [AW-1:0]    bsel,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   output logic             zero,
   output logic             carry
);

   typedef enum logic [2:0] {
      OP_HOLD = 3'b000,
      OP_LOAD = 3'b001,
      OP_INC  = 3'b010,
      OP_DEC  = 3'b011,
      OP_SHL  = 3'b100,
      OP_SHR  = 3'b101,
      OP_CLR  = 3'b110,
      OP_ROR  = 3'b111
   } op_e;

   logic [WIDTH-1:0] r_regs [DEPTH];
   logic             r_zero;
   logic             r_carry;

   logic [WIDTH-1:0] w_cur;
   logic [WIDTH-1:0] w_next;
   logic             w_carry;
   op_e              w_op;

   assign w_op  = op_e'(op);
   assign w_cur = r_regs[wsel];

   // Next value of the selected register; `in` is only looked at for LOAD.
   always_comb begin
      w_next  = w_cur;
      w_carry = r_carry;
      case (w_op)
         OP_HOLD: ;
         OP_LOAD: begin
            w_next  = in;
            w_carry = 1'b0;
         end
         OP_INC: begin
            w_next  = w_cur + WIDTH'(1);
            w_carry = &w_cur;
         end
         OP_DEC: begin
            w_next  = w_cur - WIDTH'(1);
            w_carry = ~|w_cur;
         end
         OP_SHL: begin
            w_next  = {w_cur[WIDTH-2:0], 1'b0};
            w_carry = w_cur[WIDTH-1];
         end
         OP_SHR: begin
            w_next  = {1'b0, w_cur[WIDTH-1:1]};
            w_carry = w_cur[0];
         end
         OP_CLR: begin
            w_next  = '0;
            w_carry = 1'b0;
         end
         OP_ROR: begin
            w_next  = {w_cur[0], w_cur[WIDTH-1:1]};
            w_carry = w_cur[0];
         end
         default: ;
      endcase
   end

   // HOLD leaves both the bank and the flags untouched.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
         r_zero  <= 1'b0;
         r_carry <= 1'b0;
      end else if (w_op != OP_HOLD) begin
         r_regs[wsel] <= w_next;
         r_zero       <= (w_next == '0);
         r_carry      <= w_carry;
      end
   end

   assign a_out = r_regs[asel];
   assign b_out = r_regs[bsel];
   assign zero  = r_zero;
   assign carry = r_carry;

endmodule
